spike_aer_encoder: RTL
======================

// Module: spike_aer_encoder
// PURPOSE
//  Downstream of the lif neuron array. Captures each neuron's spike (rising edge of its level
//  spike output) and serialises it as an address-event (neuron index + timestep stamp).
//  Round-robin arbitration feeds a small FIFO drained by a valid/ready consumer
//  (output pins / host interface).
// PARAMETERS
//  N_NEURONS   8  number of spike inputs (>=2)
//  ADDR_W      3  event address width, = clog2(N_NEURONS)
//  TS_W        8  timestep counter width
//  FIFO_DEPTH  4  event FIFO entries (power of 2)
// PORTS
//  clk       in   1          clock
//  reset_n   in   1          synchronous, active-low reset
//  spike_in  in   N_NEURONS  level spike lines from lif instances, synchronous to clk
//  tick      in   1          timestep strobe, one clk wide
//  ev_valid  out  1          FIFO head holds an event
//  ev_ready  in   1          consumer accepts head when ev_valid & ev_ready
//  ev_addr   out  ADDR_W     neuron index of head event
//  ev_ts     out  TS_W       timestep of head event
//  overflow  out  1          sticky: at least one spike was lost
// BEHAVIOUR
//  Reset: prev, pending, ts, rr_ptr, FIFO pointers/count, overflow all 0.
//   ev_valid=0, ev_addr=0, ev_ts=0.
//  Edge detect: rise[i] = spike_in[i] & ~prev[i]. prev <= spike_in every cycle.
//   A line already high at reset release gives one event.
//   A line held high gives exactly one event.
//  Pending: set on rise[i]; cleared on the grant to i.
//   Grant and new rise on the same i in the same cycle: the grant is consumed and pending
//   stays set, so no loss.
//   rise[i] with pending[i]=1 and no grant to i: event lost, overflow <= 1
//   (cleared only by reset).
//  Timestep: ts increments on tick and wraps 2^TS_W-1 -> 0.
//  Arbiter: one grant per cycle to the first pending index at or after rr_ptr (circular).
//   On grant: rr_ptr <= granted+1 (mod N_NEURONS).
//   Grant allowed iff count<FIFO_DEPTH, or a pop occurs in the same cycle.
//   No grant leaves rr_ptr unchanged.
//  Push: {granted idx, ts} written at the edge ending the grant cycle. ts is the pre-tick
//   value if tick is asserted in that cycle.
//  Pop: ev_valid & ev_ready at an edge. Head fields are stable while ev_valid & ~ev_ready.
//  Latency: rise sampled at edge k, no contention, FIFO not full -> ev_valid=1 after edge k+1.
//  Push+pop in the same cycle: count unchanged.
//   Full plus pop admits a push.
//   Empty plus push: no pop possible that cycle.
//  Outputs are registered or driven from FIFO registers only; no combinational path from
//   ev_ready to ev_valid.
//  Reset mid-operation: pending events and FIFO contents discarded; no event emitted after
//   reset for a spike captured before it.
// STRUCTURE
//  snn_pkg: ADDR_W/TS_W defaults; aer_event_t {addr, ts}.
//   snn_pkg is shared with the lif and synapse stages.
//  Sub-module aer_sync_fifo: sync FIFO (width ADDR_W+TS_W, depth FIFO_DEPTH) with
//   push/pop/full/empty/count and same-cycle push-at-full-with-pop.
//  Top: edge detect, pending vector, round-robin arbiter, ts counter, overflow flag.
// TESTING
//  1. Reset, ev_ready=1, spike_in[5] 0->1 held 10 cycles
//     -> exactly one event addr=5, ts=0, ev_valid 2 edges after rise.
//  2. spike_in=8'hFF in one cycle, rr_ptr=0, ev_ready=1
//     -> events addr 0..7 in order, one per cycle, overflow=0.
//  3. ev_ready=0, rises on lines 1,2,3,4,6
//     -> FIFO holds 1,2,3,4; line 6 stays pending.
//     -> Set ev_ready=1 -> 1,2,3,4,6 out, no loss.
//  4. ev_ready=0, FIFO full, line 2 rises, falls and rises again before its grant
//     -> overflow=1 and stays 1 until reset.
//  5. 255 ticks then tick coincident with grant of line 0
//     -> event ts=255; next event ts=0 (wrap).
//  6. Reset asserted with 3 events queued and 2 pending -> ev_valid=0 after reset edge;
//     no stale events after release.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN definitions: default event field widths and the address-event record.
package snn_pkg;
  localparam int SNN_ADDR_W = 3;
  localparam int SNN_TS_W   = 8;

  typedef struct packed {
    logic [SNN_ADDR_W-1:0] addr;
    logic [SNN_TS_W-1:0]   ts;
  } aer_event_t;
endpackage

// File: rtl/aer_sync_fifo.sv
// Synchronous event FIFO; a push is accepted at full when a pop happens in the same cycle.
module aer_sync_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spike_aer_encoder.sv
// Spike edge capture, round-robin arbitration and timestep stamping into an AER event FIFO.
// ADDR_W must equal clog2(N_NEURONS).
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = SNN_ADDR_W,
  parameter int TS_W       = SNN_TS_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 tick,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ADDR_W-1:0]    ev_addr,
  output logic [TS_W-1:0]      ev_ts,
  output logic                 overflow
);
  logic [N_NEURONS-1:0] r_prev, r_pending;
  logic [N_NEURONS-1:0] w_rise, w_gnt_oh, w_lost;
  logic [ADDR_W-1:0]    r_rr_ptr, w_gnt_idx;
  logic [ADDR_W:0]      w_scan;
  logic [TS_W-1:0]      r_ts;
  logic                 r_overflow;
  logic                 w_gnt_found, w_gnt, w_pop, w_can_push;
  logic                 w_full, w_empty, w_unused_full;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  assign w_rise = spike_in & ~r_prev;
  assign w_pop  = ev_valid & ev_ready;
  assign w_can_push = (w_fifo_count < ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH)) | w_pop;
  assign w_unused_full = w_full;

  // circular scan starting at the round-robin pointer
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (ADDR_W+1)'(k);
      if (w_scan >= (ADDR_W+1)'(N_NEURONS)) w_scan = w_scan - (ADDR_W+1)'(N_NEURONS);
      if (!w_gnt_found && r_pending[w_scan[ADDR_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[ADDR_W-1:0];
      end
    end
  end

  assign w_gnt    = w_gnt_found & w_can_push;
  assign w_gnt_oh = w_gnt ? (N_NEURONS'(1) << w_gnt_idx) : '0;
  // a granted line that rises again stays pending, so it is not a loss
  assign w_lost   = w_rise & r_pending & ~w_gnt_oh;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_ts       <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev    <= spike_in;
      r_pending <= (r_pending & ~w_gnt_oh) | w_rise;
      if (tick) r_ts <= r_ts + 1'b1;
      if (w_gnt)
        r_rr_ptr <= (w_gnt_idx == ADDR_W'(N_NEURONS-1)) ? '0 : w_gnt_idx + 1'b1;
      if (|w_lost) r_overflow <= 1'b1;
    end
  end

  aer_sync_fifo #(.W(ADDR_W+TS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_gnt),
    .i_din   ({w_gnt_idx, r_ts}),
    .i_pop   (ev_ready),
    .o_dout  ({ev_addr, ev_ts}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign ev_valid = ~w_empty;
  assign overflow = r_overflow;
endmodule
